inst_axi_bridge: RTL

- Instruction-side responder for the fetch unit's request/addr_ok/data_ok interface.
- Accepts fetch requests and issues single-beat 32-bit AXI4 read transactions.
- Returns the fetched word to the fetch unit with a one-cycle `inst_data_ok` pulse.
- Supports multiple outstanding reads and discards responses to requests killed by a pipeline flush.

---
 rtl/inst_axi_bridge_if.sv | 69 ++++++
 rtl/inst_axi_bridge.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/inst_axi_bridge_if.sv
// ---------------------------------------------------------------------------
// inst_axi_bridge_if
//   Bundles the fetch-unit request/addr_ok/data_ok handshake and the AXI4
//   read channels (AR and R) served by inst_axi_bridge.
//
//   modport master : the bridge itself (it masters the AXI read bus and
//                    answers the fetch unit).
//   modport slave  : the environment around it (fetch unit plus AXI memory).
//
//   Fetch side : inst_valid/op/wstrb/wdata/addr/uncache_en/cancel in,
//                inst_addr_ok/data_ok/rdata, icache_miss out.
//   AXI AR     : arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/
//                arvalid out, arready in.
//   AXI R      : rid/rdata/rresp/rlast/rvalid in, rready out.
// ---------------------------------------------------------------------------
interface inst_axi_bridge_if;
   // fetch unit side
   logic        inst_valid;
   logic        inst_op;
   logic [3:0]  inst_wstrb;
   logic [31:0] inst_wdata;
   logic [31:0] inst_addr;
   logic        inst_uncache_en;
   logic        inst_cancel;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        icache_miss;
   // AXI read-address channel
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   // AXI read-data channel
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      input  inst_valid, inst_op, inst_wstrb, inst_wdata, inst_addr,
             inst_uncache_en, inst_cancel,
      output inst_addr_ok, inst_data_ok, inst_rdata, icache_miss,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
             arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      output inst_valid, inst_op, inst_wstrb, inst_wdata, inst_addr,
             inst_uncache_en, inst_cancel,
      input  inst_addr_ok, inst_data_ok, inst_rdata, icache_miss,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
             arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/inst_axi_bridge.sv
// ---------------------------------------------------------------------------
// inst_axi_bridge
//   Instruction-side bridge: turns fetch requests into single-beat 32-bit
//   AXI4 reads, keeps up to MAX_OUTSTANDING reads in flight and returns each
//   word with a one-cycle inst_data_ok pulse. A flush (inst_cancel) marks
//   every read still in flight as stale; their R beats are swallowed.
//
//   Parameters : MAX_OUTSTANDING (1..4) accepted-but-unanswered limit,
//                AXI_ID constant driven on arid.
//   Ports      : clk, resetn (async, active-low), bus (inst_axi_bridge_if
//                master modport: fetch handshake + AXI AR/R channels).
// ---------------------------------------------------------------------------
module inst_axi_bridge #(
   parameter int         MAX_OUTSTANDING = 2,
   parameter logic [3:0] AXI_ID          = 4'd0
) (
   input  logic                 clk,
   input  logic                 resetn,
   inst_axi_bridge_if.master    bus
);

   localparam int             CW       = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0]  CNT_MAX  = CW'(MAX_OUTSTANDING);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

   // registered state
   logic          arvalid_q,  arvalid_d;
   logic [31:0]   araddr_q,   araddr_d;
   logic [3:0]    arcache_q,  arcache_d;
   logic          rready_q,   rready_d;
   logic [CW-1:0] cnt_q,      cnt_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic          data_ok_q,  data_ok_d;
   logic [31:0]   rdata_q,    rdata_d;
   logic          miss_q,     miss_d;

   // combinational events
   logic accept_s;
   logic r_hs_s;
   logic r_take_s;

   // Inputs the bridge deliberately ignores (writes never happen on this
   // port, and the single AXI ID makes rid/rresp meaningless here).
   logic unused_s;
   assign unused_s = ^{bus.inst_op, bus.inst_wstrb, bus.inst_wdata,
                       bus.inst_addr[1:0], bus.rid, bus.rresp};

   // Acceptance and R-beat qualification.
   always_comb begin
      // Gated by resetn so nothing is accepted while reset is asserted.
      accept_s = resetn & bus.inst_valid & ~arvalid_q & (cnt_q < CNT_MAX);
      r_hs_s   = bus.rvalid & rready_q & bus.rlast;
      // A beat with nothing outstanding is a slave protocol error: ignore it.
      r_take_s = r_hs_s & (cnt_q != CNT_ZERO);
   end

   // Outstanding and drop counter next-state.
   always_comb begin
      cnt_d = cnt_q;
      case ({accept_s, r_take_s})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase

      drop_cnt_d = drop_cnt_q;
      if (bus.inst_cancel) begin
         // Everything in flight before the flush is stale; the beat landing
         // in the flush cycle itself is consumed here, so exclude it.
         drop_cnt_d = r_take_s ? (cnt_q - CNT_ONE) : cnt_q;
      end else if (r_take_s && (drop_cnt_q != CNT_ZERO)) begin
         drop_cnt_d = drop_cnt_q - CNT_ONE;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   // Read-address holding register: load on accept, release on handshake.
   always_comb begin
      arvalid_d = arvalid_q;
      araddr_d  = araddr_q;
      arcache_d = arcache_q;
      if (accept_s) begin
         arvalid_d = 1'b1;
         araddr_d  = {bus.inst_addr[31:2], 2'b00};
         arcache_d = bus.inst_uncache_en ? 4'b0000 : 4'b1111;
      end else if (arvalid_q && bus.arready) begin
         arvalid_d = 1'b0;
      end else begin
         arvalid_d = arvalid_q;
      end
   end

   // Response path toward the fetch unit.
   always_comb begin
      rready_d  = 1'b1;
      data_ok_d = r_take_s & ~bus.inst_cancel & (drop_cnt_q == CNT_ZERO);
      miss_d    = data_ok_d;
      if (data_ok_d) begin
         rdata_d = bus.rdata;
      end else begin
         rdata_d = rdata_q;
      end
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         arvalid_q  <= 1'b0;
         araddr_q   <= 32'd0;
         arcache_q  <= 4'd0;
         rready_q   <= 1'b0;
         cnt_q      <= CNT_ZERO;
         drop_cnt_q <= CNT_ZERO;
         data_ok_q  <= 1'b0;
         rdata_q    <= 32'd0;
         miss_q     <= 1'b0;
      end else begin
         arvalid_q  <= arvalid_d;
         araddr_q   <= araddr_d;
         arcache_q  <= arcache_d;
         rready_q   <= rready_d;
         cnt_q      <= cnt_d;
         drop_cnt_q <= drop_cnt_d;
         data_ok_q  <= data_ok_d;
         rdata_q    <= rdata_d;
         miss_q     <= miss_d;
      end
   end

   // Output mapping.
   assign bus.inst_addr_ok = accept_s;
   assign bus.inst_data_ok = data_ok_q;
   assign bus.inst_rdata   = rdata_q;
   assign bus.icache_miss  = miss_q;
   assign bus.arid         = AXI_ID;
   assign bus.araddr       = araddr_q;
   assign bus.arlen        = 8'd0;
   assign bus.arsize       = 3'b010;
   assign bus.arburst      = 2'b01;
   assign bus.arlock       = 2'b00;
   assign bus.arcache      = arcache_q;
   assign bus.arprot       = 3'b000;
   assign bus.arvalid      = arvalid_q;
   assign bus.rready       = rready_q;

endmodule
